// File: rtl/ema_multichannel.sv
// Time-multiplexed exponential moving average, s += alpha*(x - s), shared by N_CH channels.
// Optional EMA_PRELOAD_EN: the first sample on an unprimed channel loads the state directly.
module ema_multichannel #(
    parameter int DATA_W = 27,
    parameter int COEF_W = 18,
    parameter int N_CH   = 4,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_chan,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [COEF_W-1:0]        in_coef,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_chan,
    output logic signed [DATA_W-1:0] out_data
);
    localparam int SW = DATA_W + COEF_W;
    localparam int DW = SW + 1;
    localparam int PW = SW + COEF_W + 2;
    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    // Handshake: in_valid qualifies in_chan/in_data/in_coef for one cycle and there is no
    // ready; every in-range sample is taken and yields exactly one out_valid pulse 3 edges later.

    function automatic logic signed [PW-1:0] mul_step(input logic signed [DATA_W-1:0] x,
                                                      input logic [COEF_W-1:0]        coef,
                                                      input logic signed [SW-1:0]     s);
        logic signed [DW-1:0] d;
        d = (DW'(x) <<< COEF_W) - DW'(s);
        return PW'($signed({1'b0, coef})) * PW'(d);
    endfunction

    function automatic logic signed [SW-1:0] acc_step(input logic signed [SW-1:0] s,
                                                      input logic signed [PW-1:0] p);
        return s + SW'(p >>> COEF_W);
    endfunction

    logic                     accept;
    logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [CH_W-1:0]          chan1_q, chan1_d, chan2_q, chan2_d, chan3_q, chan3_d;
    logic signed [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;
    logic [COEF_W-1:0]        coef1_q, coef1_d, coef2_q, coef2_d;
    logic signed [SW-1:0]     s2_q, s2_d, s3_q, s3_d;
    logic signed [PW-1:0]     p3_q, p3_d, p2;
    logic signed [SW-1:0]     s_rd, s_new2, s_new3;
    logic signed [SW-1:0]     s_mem_q [N_CH];
    logic signed [SW-1:0]     s_mem_d [N_CH];
    logic                     out_valid_q, out_valid_d;
    logic [CH_W-1:0]          out_chan_q, out_chan_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     fwd2, fwd3;
`ifdef EMA_PRELOAD_EN
    logic [N_CH-1:0]          pr_mem_q, pr_mem_d;
    logic                     pr_rd, pr2_q, pr2_d, pr3_q, pr3_d;
    logic signed [DATA_W-1:0] x3_q, x3_d;
`endif

    // Update arithmetic for the items in S2 (forwarding only) and S3 (commit).
    always_comb begin
        p2     = mul_step(x2_q, coef2_q, s2_q);
        s_new2 = acc_step(s2_q, p2);
        s_new3 = acc_step(s3_q, p3_q);
`ifdef EMA_PRELOAD_EN
        if (!pr2_q) s_new2 = SW'(x2_q) <<< COEF_W;
        if (!pr3_q) s_new3 = SW'(x3_q) <<< COEF_W;
`endif
    end

    // State read for S1; S2 is younger than S3, so it is applied last and wins.
    always_comb begin
        fwd2 = v2_q && (chan2_q == chan1_q);
        fwd3 = v3_q && (chan3_q == chan1_q);
        s_rd = s_mem_q[chan1_q];
        if (fwd3) s_rd = s_new3;
        if (fwd2) s_rd = s_new2;
`ifdef EMA_PRELOAD_EN
        pr_rd = pr_mem_q[chan1_q] | fwd2 | fwd3;
`endif
    end

    always_comb begin
        accept  = in_valid && ({1'b0, in_chan} < N_CH_L);
        v1_d    = accept;
        chan1_d = chan1_q;
        x1_d    = x1_q;
        coef1_d = coef1_q;
        if (accept) begin
            chan1_d = in_chan;
            x1_d    = in_data;
            coef1_d = in_coef;
        end
        v2_d    = v1_q;
        chan2_d = chan1_q;
        x2_d    = x1_q;
        coef2_d = coef1_q;
        s2_d    = s_rd;
        v3_d    = v2_q;
        chan3_d = chan2_q;
        s3_d    = s2_q;
        p3_d    = p2;
        out_valid_d = v3_q;
        out_chan_d  = out_chan_q;
        out_data_d  = out_data_q;
        s_mem_d     = s_mem_q;
        if (v3_q) begin
            out_chan_d         = chan3_q;
            out_data_d         = DATA_W'(s_new3 >>> COEF_W);
            s_mem_d[chan3_q]   = s_new3;
        end
`ifdef EMA_PRELOAD_EN
        pr2_d    = pr_rd;
        pr3_d    = pr2_q;
        x3_d     = x2_q;
        pr_mem_d = pr_mem_q;
        if (v3_q) pr_mem_d[chan3_q] = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;  v2_q <= 1'b0;  v3_q <= 1'b0;
            chan1_q <= '0; chan2_q <= '0; chan3_q <= '0;
            x1_q <= '0;    x2_q <= '0;
            coef1_q <= '0; coef2_q <= '0;
            s2_q <= '0;    s3_q <= '0;    p3_q <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            for (int i = 0; i < N_CH; i++) s_mem_q[i] <= '0;
`ifdef EMA_PRELOAD_EN
            pr2_q <= 1'b0; pr3_q <= 1'b0; x3_q <= '0;
            pr_mem_q <= '0;
`endif
        end else begin
            v1_q <= v1_d;  v2_q <= v2_d;  v3_q <= v3_d;
            chan1_q <= chan1_d; chan2_q <= chan2_d; chan3_q <= chan3_d;
            x1_q <= x1_d;  x2_q <= x2_d;
            coef1_q <= coef1_d; coef2_q <= coef2_d;
            s2_q <= s2_d;  s3_q <= s3_d;  p3_q <= p3_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < N_CH; i++) s_mem_q[i] <= s_mem_d[i];
`ifdef EMA_PRELOAD_EN
            pr2_q <= pr2_d; pr3_q <= pr3_d; x3_q <= x3_d;
            pr_mem_q <= pr_mem_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_data  = out_data_q;

endmodule
